// File: rtl/rv32_regs_arb_pkg.sv
// -----------------------------------------------------------------------------
// rv32_regs_arb_pkg
// Shared types and defaults for the register-file write-port arbiter.
//   wr_req_t       : one queued register write (destination + data)
//   grant_t        : who owns the register-file write port in a given cycle
//   reg_mask()     : one-hot mask for a register index, x0 maps to no bits
// Configuration macro used by the arbiter: RV32_REGS_ARB_EARLY_RELEASE_EN
// -----------------------------------------------------------------------------
package rv32_regs_arb_pkg;

    localparam int DEFAULT_AUX_DEPTH    = 4;
    localparam int DEFAULT_STARVE_LIMIT = 8;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] value;
    } wr_req_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WB,
        GNT_AUX,
        GNT_AUX_FORCE
    } grant_t;

    // x0 is hardwired to zero, so it never appears in any scoreboard mask.
    function automatic logic [31:0] reg_mask(input logic [4:0] r);
        logic [31:0] m;
        m = 32'd0;
        if (r != 5'd0) begin
            m = 32'd1 << r;
        end
        return m;
    endfunction

endpackage

// File: rtl/rv32_regs_arb_fifo.sv
// -----------------------------------------------------------------------------
// rv32_regs_arb_fifo
// Small synchronous FIFO of wr_req_t entries feeding the aux side of the
// write-port arbiter. The head entry is presented combinationally so the
// arbiter can grant and register it in the same cycle. No fall-through: an
// entry pushed into an empty FIFO only shows up after the push edge.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset (pointers only)
//   push, push_data   enqueue request (caller guarantees room or a same-cycle pop)
//   pop               dequeue request (caller guarantees non-empty)
//   head              oldest entry
//   full, empty       status flags
// -----------------------------------------------------------------------------
module rv32_regs_arb_fifo
    import rv32_regs_arb_pkg::*;
#(
    parameter int DEPTH = DEFAULT_AUX_DEPTH
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    push,
    input  wr_req_t push_data,
    input  logic    pop,
    output wr_req_t head,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    wr_req_t       mem_reg [DEPTH];
    // One extra pointer bit separates "full" from "empty" when indices match.
    logic [AW:0]   wr_ptr_reg;
    logic [AW:0]   rd_ptr_reg;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign head  = mem_reg[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
        end
    end

    // Storage carries no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/rv32_regs_wr_arbiter.sv
// -----------------------------------------------------------------------------
// rv32_regs_wr_arbiter
// Shares the single register-file write port between pipeline writeback
// (primary) and an auxiliary long-latency requester queued through a FIFO.
// Writeback wins by default; once aux has been denied STARVE_LIMIT cycles in a
// row it is forced through and writeback is stalled for that cycle. A 32-bit
// scoreboard tracks registers still owed by the aux unit for decode hazards.
// Ports:
//   wb_*          writeback request (valid, flush, rd, value)
//   aux_*         aux valid/ready write request
//   reserve_*     mark a register pending when a long-latency op issues
//   rs1_in/rs2_in decode operands, hazard_out = either one pending
//   wb_stall_out  writeback must hold this cycle (aux forced through)
//   rd_*_out      registered register-file write port
//   pending_out   scoreboard, bit n = xn owed by aux
// Optional: RV32_REGS_ARB_EARLY_RELEASE_EN -- hazard_out ignores a register
// whose aux pop is granted in the same cycle.
// -----------------------------------------------------------------------------
module rv32_regs_wr_arbiter
    import rv32_regs_arb_pkg::*;
#(
    parameter int AUX_DEPTH    = DEFAULT_AUX_DEPTH,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wb_valid_in,
    input  logic        wb_flush_in,
    input  logic [4:0]  wb_rd_in,
    input  logic [31:0] wb_value_in,
    input  logic        aux_valid_in,
    output logic        aux_ready_out,
    input  logic [4:0]  aux_rd_in,
    input  logic [31:0] aux_value_in,
    input  logic        reserve_in,
    input  logic [4:0]  reserve_rd_in,
    input  logic [4:0]  rs1_in,
    input  logic [4:0]  rs2_in,
    output logic        hazard_out,
    output logic        wb_stall_out,
    output logic        rd_write_out,
    output logic [4:0]  rd_out,
    output logic [31:0] rd_value_out,
    output logic [31:0] pending_out
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    grant_t        grant;
    logic [CW-1:0] starve_reg;
    logic [CW-1:0] starve_next;
    logic [31:0]   pending_reg;
    logic [31:0]   pending_next;
    logic          rd_write_reg;
    logic          rd_write_next;
    logic [4:0]    rd_reg;
    logic [4:0]    rd_next;
    logic [31:0]   rd_value_reg;
    logic [31:0]   rd_value_next;

    logic          wb_req;
    logic          aux_push;
    logic          aux_pop;
    logic          fifo_full;
    logic          fifo_empty;
    wr_req_t       aux_head;
    wr_req_t       aux_in;
    logic [31:0]   set_mask;
    logic [31:0]   clr_mask;
    logic [31:0]   hazard_view;

    assign wb_req = wb_valid_in && !wb_flush_in && (wb_rd_in != 5'd0);
    assign aux_in = '{rd: aux_rd_in, value: aux_value_in};

    rv32_regs_arb_fifo #(
        .DEPTH (AUX_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (aux_push),
        .push_data (aux_in),
        .pop       (aux_pop),
        .head      (aux_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Grant selection and starvation counter.
    always_comb begin
        grant       = GNT_NONE;
        starve_next = starve_reg;
        if ((starve_reg == LIMIT) && !fifo_empty) begin
            grant       = GNT_AUX_FORCE;
            starve_next = '0;
        end else if (wb_req) begin
            grant = GNT_WB;
            if (!fifo_empty && (starve_reg != LIMIT)) begin
                starve_next = starve_reg + CW'(1);
            end
        end else if (!fifo_empty) begin
            grant       = GNT_AUX;
            starve_next = '0;
        end
    end

    assign aux_pop       = (grant == GNT_AUX) || (grant == GNT_AUX_FORCE);
    // A pop frees a slot this cycle, so a full FIFO can still accept a push.
    assign aux_ready_out = !fifo_full || aux_pop;
    assign aux_push      = aux_valid_in && aux_ready_out;
    assign wb_stall_out  = (grant == GNT_AUX_FORCE);

    // Register-file write port contents for the next edge.
    always_comb begin
        rd_write_next = 1'b0;
        rd_next       = 5'd0;
        rd_value_next = 32'd0;
        case (grant)
            GNT_WB: begin
                rd_write_next = 1'b1;
                rd_next       = wb_rd_in;
                rd_value_next = wb_value_in;
            end
            GNT_AUX, GNT_AUX_FORCE: begin
                // Aux results for x0 are drained but never written.
                if (aux_head.rd != 5'd0) begin
                    rd_write_next = 1'b1;
                    rd_next       = aux_head.rd;
                    rd_value_next = aux_head.value;
                end
            end
            default: begin
            end
        endcase
    end

    // Scoreboard: set applied after clear so a same-register reserve wins.
    assign set_mask     = reserve_in ? reg_mask(reserve_rd_in) : 32'd0;
    assign clr_mask     = aux_pop ? reg_mask(aux_head.rd) : 32'd0;
    assign pending_next = (pending_reg & ~clr_mask) | set_mask;

`ifdef RV32_REGS_ARB_EARLY_RELEASE_EN
    // The popped value is in the regfile by the time decode reads it.
    assign hazard_view = pending_reg & ~clr_mask;
`else
    assign hazard_view = pending_reg;
`endif

    assign hazard_out = ((rs1_in != 5'd0) && hazard_view[rs1_in]) ||
                        ((rs2_in != 5'd0) && hazard_view[rs2_in]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_reg   <= '0;
            pending_reg  <= 32'd0;
            rd_write_reg <= 1'b0;
            rd_reg       <= 5'd0;
            rd_value_reg <= 32'd0;
        end else begin
            starve_reg   <= starve_next;
            pending_reg  <= pending_next;
            rd_write_reg <= rd_write_next;
            rd_reg       <= rd_next;
            rd_value_reg <= rd_value_next;
        end
    end

    assign rd_write_out = rd_write_reg;
    assign rd_out       = rd_reg;
    assign rd_value_out = rd_value_reg;
    assign pending_out  = pending_reg;

endmodule

// File: tb/tb_rv32_regs_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rv32_regs_wr_arbiter
// Directed scenarios for the register-file write-port arbiter. Inputs are
// driven just after the falling edge; registered outputs are checked at the
// falling edge, combinational outputs 1 ns after inputs change.
// -----------------------------------------------------------------------------
module tb_rv32_regs_wr_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wb_valid_in;
    logic        wb_flush_in;
    logic [4:0]  wb_rd_in;
    logic [31:0] wb_value_in;
    logic        aux_valid_in;
    logic        aux_ready_out;
    logic [4:0]  aux_rd_in;
    logic [31:0] aux_value_in;
    logic        reserve_in;
    logic [4:0]  reserve_rd_in;
    logic [4:0]  rs1_in;
    logic [4:0]  rs2_in;
    logic        hazard_out;
    logic        wb_stall_out;
    logic        rd_write_out;
    logic [4:0]  rd_out;
    logic [31:0] rd_value_out;
    logic [31:0] pending_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rv32_regs_wr_arbiter dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .wb_valid_in   (wb_valid_in),
        .wb_flush_in   (wb_flush_in),
        .wb_rd_in      (wb_rd_in),
        .wb_value_in   (wb_value_in),
        .aux_valid_in  (aux_valid_in),
        .aux_ready_out (aux_ready_out),
        .aux_rd_in     (aux_rd_in),
        .aux_value_in  (aux_value_in),
        .reserve_in    (reserve_in),
        .reserve_rd_in (reserve_rd_in),
        .rs1_in        (rs1_in),
        .rs2_in        (rs2_in),
        .hazard_out    (hazard_out),
        .wb_stall_out  (wb_stall_out),
        .rd_write_out  (rd_write_out),
        .rd_out        (rd_out),
        .rd_value_out  (rd_value_out),
        .pending_out   (pending_out)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        wb_valid_in   = 1'b0;
        wb_flush_in   = 1'b0;
        wb_rd_in      = 5'd0;
        wb_value_in   = 32'd0;
        aux_valid_in  = 1'b0;
        aux_rd_in     = 5'd0;
        aux_value_in  = 32'd0;
        reserve_in    = 1'b0;
        reserve_rd_in = 5'd0;
        rs1_in        = 5'd0;
        rs2_in        = 5'd0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (rd_write_out !== 1'b0) begin n_fail++; $display("FAIL reset_rd_write got %b want 0", rd_write_out); end
        n_checks++;
        if (rd_out !== 5'd0) begin n_fail++; $display("FAIL reset_rd got %0d want 0", rd_out); end
        n_checks++;
        if (rd_value_out !== 32'd0) begin n_fail++; $display("FAIL reset_value got %h want 0", rd_value_out); end
        n_checks++;
        if (pending_out !== 32'd0) begin n_fail++; $display("FAIL reset_pending got %h want 0", pending_out); end
        n_checks++;
        if (aux_ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_aux_ready got %b want 1", aux_ready_out); end
        n_checks++;
        if (wb_stall_out !== 1'b0 || hazard_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall_hazard got stall=%b hazard=%b want 0/0", wb_stall_out, hazard_out);
        end
        reset_n = 1'b1;
        tick();
        $display("test_reset: reset released");
    endtask

    task automatic test_wb_single();
        wb_valid_in = 1'b1; wb_rd_in = 5'd5; wb_value_in = 32'h11;
        tick();
        wb_valid_in = 1'b0;
        n_checks++;
        if (rd_write_out !== 1'b1 || rd_out !== 5'd5 || rd_value_out !== 32'h11) begin
            n_fail++;
            $display("FAIL wb_single got we=%b rd=%0d val=%h want 1/5/00000011", rd_write_out, rd_out, rd_value_out);
        end
        tick();
        n_checks++;
        if (rd_write_out !== 1'b0) begin n_fail++; $display("FAIL wb_single_idle got we=%b want 0", rd_write_out); end
        $display("test_wb_single: wb x5=0x11");
    endtask

    task automatic test_aux_reserve();
        logic exp_haz_pop;
`ifdef RV32_REGS_ARB_EARLY_RELEASE_EN
        exp_haz_pop = 1'b0;
`else
        exp_haz_pop = 1'b1;
`endif
        reserve_in = 1'b1; reserve_rd_in = 5'd7; rs1_in = 5'd7;
        #1;
        n_checks++;
        if (hazard_out !== 1'b0) begin n_fail++; $display("FAIL haz_before_reserve got %b want 0", hazard_out); end
        tick();
        reserve_in = 1'b0;
        n_checks++;
        if (pending_out !== 32'h0000_0080) begin n_fail++; $display("FAIL pending_set got %h want 00000080", pending_out); end
        aux_valid_in = 1'b1; aux_rd_in = 5'd7; aux_value_in = 32'hAB;
        #1;
        n_checks++;
        if (hazard_out !== 1'b1 || aux_ready_out !== 1'b1) begin
            n_fail++; $display("FAIL haz_pending got haz=%b rdy=%b want 1/1", hazard_out, aux_ready_out);
        end
        tick();
        aux_valid_in = 1'b0;
        #1;
        n_checks++;
        if (hazard_out !== exp_haz_pop) begin n_fail++; $display("FAIL haz_pop_cycle got %b want %b", hazard_out, exp_haz_pop); end
        n_checks++;
        if (pending_out !== 32'h0000_0080) begin n_fail++; $display("FAIL pending_before_pop got %h want 00000080", pending_out); end
        tick();
        n_checks++;
        if (rd_write_out !== 1'b1 || rd_out !== 5'd7 || rd_value_out !== 32'hAB) begin
            n_fail++; $display("FAIL aux_write got we=%b rd=%0d val=%h want 1/7/000000ab", rd_write_out, rd_out, rd_value_out);
        end
        n_checks++;
        if (pending_out !== 32'd0 || hazard_out !== 1'b0) begin
            n_fail++; $display("FAIL pending_clear got pend=%h haz=%b want 0/0", pending_out, hazard_out);
        end
        rs1_in = 5'd0;
        $display("test_aux_reserve: reserve x7, aux x7=0xAB");
    endtask

    task automatic test_starve();
        for (int i = 0; i < 10; i++) begin
            wb_valid_in = 1'b1; wb_rd_in = 5'd3; wb_value_in = 32'(i);
            aux_valid_in = (i == 0); aux_rd_in = 5'd9; aux_value_in = 32'h99;
            #1;
            n_checks++;
            if (wb_stall_out !== (i == 9)) begin
                n_fail++; $display("FAIL starve_stall cycle %0d got %b want %b", i, wb_stall_out, (i == 9));
            end
            tick();
            n_checks++;
            if (i == 9) begin
                if (rd_write_out !== 1'b1 || rd_out !== 5'd9 || rd_value_out !== 32'h99) begin
                    n_fail++; $display("FAIL starve_force got we=%b rd=%0d val=%h want 1/9/00000099", rd_write_out, rd_out, rd_value_out);
                end
            end else if (rd_write_out !== 1'b1 || rd_out !== 5'd3 || rd_value_out !== 32'(i)) begin
                n_fail++; $display("FAIL starve_wb cycle %0d got we=%b rd=%0d val=%h want 1/3/%h", i, rd_write_out, rd_out, rd_value_out, 32'(i));
            end
        end
        clear_inputs();
        tick();
        $display("test_starve: aux x9 forced after 8 denials");
    endtask

    task automatic test_fifo_full();
        logic exp_rdy;
        for (int i = 0; i < 11; i++) begin
            wb_valid_in = 1'b1; wb_rd_in = 5'd4; wb_value_in = 32'h4000 + 32'(i);
            aux_valid_in = (i <= 9);
            aux_rd_in    = (i < 4) ? 5'(10 + i) : 5'd14;
            aux_value_in = 32'h100 + 32'(aux_rd_in);
            exp_rdy = (i < 4) || (i == 9);
            #1;
            n_checks++;
            if (aux_ready_out !== exp_rdy || wb_stall_out !== (i == 9)) begin
                n_fail++; $display("FAIL full_ready cycle %0d got rdy=%b stall=%b want %b/%b", i, aux_ready_out, wb_stall_out, exp_rdy, (i == 9));
            end
            tick();
        end
        n_checks++;
        if (rd_out !== 5'd4) begin n_fail++; $display("FAIL full_wb_after_force got rd=%0d want 4", rd_out); end
        clear_inputs();
        for (int k = 11; k <= 14; k++) begin
            tick();
            n_checks++;
            if (rd_write_out !== 1'b1 || rd_out !== 5'(k) || rd_value_out !== 32'h100 + 32'(k)) begin
                n_fail++; $display("FAIL drain got we=%b rd=%0d val=%h want 1/%0d/%h", rd_write_out, rd_out, rd_value_out, k, 32'h100 + 32'(k));
            end
        end
        tick();
        n_checks++;
        if (rd_write_out !== 1'b0 || aux_ready_out !== 1'b1) begin
            n_fail++; $display("FAIL drained got we=%b rdy=%b want 0/1", rd_write_out, aux_ready_out);
        end
        $display("test_fifo_full: 4 queued, 5th held, pop+push when full");
    endtask

    task automatic test_flush();
        aux_valid_in = 1'b1; aux_rd_in = 5'd6; aux_value_in = 32'h66;
        tick();
        aux_valid_in = 1'b0;
        wb_valid_in = 1'b1; wb_flush_in = 1'b1; wb_rd_in = 5'd5; wb_value_in = 32'h55;
        tick();
        n_checks++;
        if (rd_write_out !== 1'b1 || rd_out !== 5'd6 || rd_value_out !== 32'h66) begin
            n_fail++; $display("FAIL flush_aux_slot got we=%b rd=%0d val=%h want 1/6/00000066", rd_write_out, rd_out, rd_value_out);
        end
        wb_flush_in = 1'b0; wb_rd_in = 5'd0;
        tick();
        n_checks++;
        if (rd_write_out !== 1'b0) begin n_fail++; $display("FAIL wb_x0 got we=%b want 0", rd_write_out); end
        wb_flush_in = 1'b1; wb_rd_in = 5'd5;
        tick();
        n_checks++;
        if (rd_write_out !== 1'b0) begin n_fail++; $display("FAIL flush_only got we=%b want 0", rd_write_out); end
        clear_inputs();
        aux_valid_in = 1'b1; aux_rd_in = 5'd0; aux_value_in = 32'h77;
        tick();
        aux_valid_in = 1'b0;
        tick();
        n_checks++;
        if (rd_write_out !== 1'b0) begin n_fail++; $display("FAIL aux_x0 got we=%b want 0", rd_write_out); end
        $display("test_flush: flushed/x0 wb and x0 aux not written");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            wb_valid_in = 1'b1; wb_rd_in = 5'd2; wb_value_in = 32'h22;
            reserve_in = (i == 0); reserve_rd_in = 5'd9;
            aux_valid_in = (i < 3); aux_rd_in = 5'(20 + i); aux_value_in = 32'h200 + 32'(i);
            tick();
        end
        n_checks++;
        if (pending_out !== 32'h0000_0200 || rd_write_out !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset got pend=%h we=%b want 00000200/1", pending_out, rd_write_out);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (rd_write_out !== 1'b0 || pending_out !== 32'd0 || aux_ready_out !== 1'b1) begin
            n_fail++; $display("FAIL async_reset got we=%b pend=%h rdy=%b want 0/0/1", rd_write_out, pending_out, aux_ready_out);
        end
        clear_inputs();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (rd_write_out !== 1'b0) begin n_fail++; $display("FAIL post_reset_empty cycle %0d got we=%b want 0", i, rd_write_out); end
        end
        $display("test_reset_mid: queued aux discarded");
    endtask

    initial begin
        test_reset();
        test_wb_single();
        test_aux_reserve();
        test_starve();
        test_fifo_full();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
